// File: rtl/core_pkg.sv
// Shared types and constants for the RV32IC core pipeline.
// Imported by the fetch stage and its next-PC selector.
package core_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic        fault;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        c;
  } if_id_t;

  localparam logic [31:0] ILEN_C = 32'd2;
  localparam logic [31:0] ILEN_I = 32'd4;

  function automatic logic [31:0] ilen(input logic c);
    return c ? ILEN_C : ILEN_I;
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection for fetch: redirect priority mux,
// sequential increment and fetch fault detection.
module next_pc_sel
  import core_pkg::*;
#(
  parameter int IMEM_BYTES = 64
) (
  input  logic [31:0] pc,
  input  logic        instr_c,
  input  logic        trap,
  input  logic [31:0] trap_vec,
  input  logic        mret,
  input  logic [31:0] mepc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        redir,
  output logic [31:0] redir_pc,
  output logic [31:0] seq_pc,
  output logic        fault
);

  localparam logic [32:0] LIMIT = 33'(IMEM_BYTES);

  logic [31:0] len;
  logic [32:0] end_addr;

  assign len      = ilen(instr_c);
  assign seq_pc   = pc + len;
  // Wide sum so an access that wraps past 2^32 still faults.
  assign end_addr = {1'b0, pc} + {1'b0, len};
  assign fault    = pc[0] | (end_addr > LIMIT);
  assign redir    = trap | mret | br_taken;

  always_comb begin
    redir_pc = br_target;
    if (trap) begin
      redir_pc = trap_vec;
    end else if (mret) begin
      redir_pc = mepc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register
// and the RUN/HALT fault state machine.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        instr_c_i,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        trap_i,
  input  logic [31:0] trap_vec_i,
  input  logic        mret_i,
  input  logic [31:0] mepc_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        if_c_o,
  output logic        if_fault_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  if_id_t       ifid_q, ifid_d;

  logic        redir;
  logic [31:0] redir_pc;
  logic [31:0] seq_pc;
  logic        fault;

  next_pc_sel #(
    .IMEM_BYTES(IMEM_BYTES)
  ) u_sel (
    .pc       (pc_q),
    .instr_c  (instr_c_i),
    .trap     (trap_i),
    .trap_vec (trap_vec_i),
    .mret     (mret_i),
    .mepc     (mepc_i),
    .br_taken (br_taken_i),
    .br_target(br_target_i),
    .redir    (redir),
    .redir_pc (redir_pc),
    .seq_pc   (seq_pc),
    .fault    (fault)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      ifid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    if (redir) begin
      // Redirect beats stall and HALT; its target fetches next cycle.
      pc_d         = redir_pc;
      ifid_d.valid = 1'b0;
      state_d      = RUN;
    end else if (stall_i) begin
      state_d = state_q;
    end else if (state_q == HALT) begin
      ifid_d.valid = 1'b0;
    end else if (fault) begin
      ifid_d.valid = 1'b1;
      ifid_d.fault = 1'b1;
      ifid_d.pc    = pc_q;
      ifid_d.instr = '0;
      ifid_d.c     = 1'b0;
      state_d      = HALT;
    end else begin
      ifid_d.valid = 1'b1;
      ifid_d.fault = 1'b0;
      ifid_d.pc    = pc_q;
      ifid_d.instr = imem_instr_i;
      ifid_d.c     = instr_c_i;
      pc_d         = seq_pc;
    end
  end

  assign imem_addr_o = pc_q;
  assign if_valid_o  = ifid_q.valid;
  assign if_pc_o     = ifid_q.pc;
  assign if_instr_o  = ifid_q.instr;
  assign if_c_o      = ifid_q.c;
  assign if_fault_o  = ifid_q.fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage with a pattern-based
// instruction memory (word = 0xA500_0000 | address).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        instr_c;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        trap;
  logic [31:0] trap_vec;
  logic        mret;
  logic [31:0] mepc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_c;
  logic        if_fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_instr = 32'hA500_0000 | imem_addr;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_BYTES(64)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .imem_addr_o (imem_addr),
    .imem_instr_i(imem_instr),
    .instr_c_i   (instr_c),
    .stall_i     (stall),
    .br_taken_i  (br_taken),
    .br_target_i (br_target),
    .trap_i      (trap),
    .trap_vec_i  (trap_vec),
    .mret_i      (mret),
    .mepc_i      (mepc),
    .if_valid_o  (if_valid),
    .if_pc_o     (if_pc),
    .if_instr_o  (if_instr),
    .if_c_o      (if_c),
    .if_fault_o  (if_fault)
  );

  // op: 0 run, 1 reset, 2 stall, 3 branch, 4 trap+branch,
  //     5 mret, 6 branch+stall
  typedef struct {
    int          op;
    logic        c;
    logic [31:0] tgt;
    logic        full;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_c;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int op, logic c, logic [31:0] tgt,
                              logic full, logic [31:0] ea,
                              logic ev, logic [31:0] ep,
                              logic ec, logic ef);
    vec_t v;
    v.op = op; v.c = c; v.tgt = tgt; v.full = full;
    v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
    v.e_c = ec; v.e_fault = ef;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst = 0; stall = 0; instr_c = 0;
    br_taken = 0; br_target = 0;
    trap = 0; trap_vec = 0; mret = 0; mepc = 0;
  endtask

  task automatic apply(vec_t v);
    idle();
    instr_c = v.c;
    case (v.op)
      1: rst = 1;
      2: stall = 1;
      3: begin br_taken = 1; br_target = v.tgt; end
      4: begin
        trap = 1; trap_vec = v.tgt;
        br_taken = 1; br_target = 32'h10;
      end
      5: begin mret = 1; mepc = v.tgt; end
      6: begin
        br_taken = 1; br_target = v.tgt; stall = 1;
      end
      default: ;
    endcase
  endtask

  task automatic compare(int i, vec_t v);
    logic [31:0] e_instr;
    string s;
    s = $sformatf("v%0d", i);
    check({s, ".addr"}, imem_addr, v.e_addr);
    check({s, ".valid"}, {31'b0, if_valid}, {31'b0, v.e_valid});
    if (v.full) begin
      e_instr = (v.e_valid && !v.e_fault) ?
                (32'hA500_0000 | v.e_pc) : 32'h0;
      check({s, ".pc"}, if_pc, v.e_pc);
      check({s, ".instr"}, if_instr, e_instr);
      check({s, ".c"}, {31'b0, if_c}, {31'b0, v.e_c});
      check({s, ".fault"}, {31'b0, if_fault}, {31'b0, v.e_fault});
    end
  endtask

  initial begin
    idle();
    rst = 1;
    // reset state
    vecs.push_back(mk(1, 0, 0,     1, 32'h00, 0, 32'h00, 0, 0));
    vecs.push_back(mk(1, 0, 0,     1, 32'h00, 0, 32'h00, 0, 0));
    // free run, compressed mix
    vecs.push_back(mk(0, 0, 0,     1, 32'h04, 1, 32'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0,     1, 32'h08, 1, 32'h04, 0, 0));
    vecs.push_back(mk(0, 1, 0,     1, 32'h0A, 1, 32'h08, 1, 0));
    vecs.push_back(mk(0, 0, 0,     1, 32'h0E, 1, 32'h0A, 0, 0));
    vecs.push_back(mk(0, 0, 0,     1, 32'h12, 1, 32'h0E, 0, 0));
    // branch with stall: redirect wins
    vecs.push_back(mk(6, 0, 32'h20, 0, 32'h20, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,     1, 32'h24, 1, 32'h20, 0, 0));
    // trap beats branch
    vecs.push_back(mk(4, 0, 32'h30, 0, 32'h30, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,     1, 32'h34, 1, 32'h30, 0, 0));
    // plain stall holds everything
    vecs.push_back(mk(2, 0, 0,     1, 32'h34, 1, 32'h30, 0, 0));
    // end-of-memory fault at 0x3E with 32-bit word
    vecs.push_back(mk(3, 0, 32'h3E, 0, 32'h3E, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,     1, 32'h3E, 1, 32'h3E, 0, 1));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 0, 0,   0, 32'h3E, 0, 0, 0, 0));
    vecs.push_back(mk(5, 0, 32'h04, 0, 32'h04, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,     1, 32'h08, 1, 32'h04, 0, 0));
    // odd PC fault
    vecs.push_back(mk(3, 0, 32'h3F, 0, 32'h3F, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0,     1, 32'h3F, 1, 32'h3F, 0, 1));
    // redirect coinciding with a fault condition
    vecs.push_back(mk(3, 0, 32'h3C, 0, 32'h3C, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0,     1, 32'h3E, 1, 32'h3C, 1, 0));
    vecs.push_back(mk(3, 0, 32'h10, 0, 32'h10, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0,     1, 32'h12, 1, 32'h10, 1, 0));
    // compressed exactly at the last halfword is legal
    vecs.push_back(mk(3, 0, 32'h3E, 0, 32'h3E, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0,     1, 32'h40, 1, 32'h3E, 1, 0));
    vecs.push_back(mk(0, 1, 0,     1, 32'h40, 1, 32'h40, 0, 1));
    // reset while halted
    vecs.push_back(mk(1, 0, 0,     1, 32'h00, 0, 32'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0,     1, 32'h04, 1, 32'h00, 0, 0));

    @(negedge clk);
    foreach (vecs[i]) begin
      apply(vecs[i]);
      @(posedge clk);
      #1;
      compare(i, vecs[i]);
      @(negedge clk);
    end

    // reset during stall forces the reset state
    idle();
    rst = 1; stall = 1;
    @(posedge clk); #1;
    check("rst_stall.addr", imem_addr, 32'h0);
    check("rst_stall.valid", {31'b0, if_valid}, 32'h0);
    check("rst_stall.pc", if_pc, 32'h0);
    @(negedge clk);
    // mret outranks a same-cycle branch
    idle();
    mret = 1; mepc = 32'h18; br_taken = 1; br_target = 32'h2C;
    @(posedge clk); #1;
    check("mret_br.addr", imem_addr, 32'h18);
    @(negedge clk);
    idle();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("run%0d.pc", k), if_pc, 32'h18 + 4 * k);
      check($sformatf("run%0d.instr", k), if_instr,
            32'hA500_0000 | (32'h18 + 4 * k));
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
